// File: rtl/fft_controller_pkg.sv
// rtl/fft_controller_pkg.sv - shared sizes, FSM state type and write-back tap record for the FFT controller
package fft_controller_pkg;

  localparam int FFT_N      = 16;
  localparam int FFT_STAGES = 4;
  localparam int FFT_BFLIES = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_COMPUTE,
    ST_DRAIN,
    ST_UNLOAD
  } fft_state_e;

  typedef struct packed {
    logic       en;
    logic [1:0] stage;
    logic [2:0] bfly;
  } wb_tap_t;

  function automatic logic [3:0] bitrev4(input logic [3:0] v);
    return {v[0], v[1], v[2], v[3]};
  endfunction

endpackage

// File: rtl/fft_wb_delay.sv
// rtl/fft_wb_delay.sv - delays butterfly issue/stage/index by BF_LATENCY cycles to form write-back controls
module fft_wb_delay
  import fft_controller_pkg::*;
#(
  parameter int BF_LATENCY = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       issue_i,
  input  logic [1:0] stage_i,
  input  logic [2:0] bfly_i,
  output logic       wb_en_o,
  output logic [1:0] wb_stage_o,
  output logic [2:0] wb_bfly_o
);

  wb_tap_t pipe_q [BF_LATENCY];
  wb_tap_t pipe_d [BF_LATENCY];

  always_comb begin
    pipe_d[0] = '{en: issue_i, stage: stage_i, bfly: bfly_i};
    for (int i = 1; i < BF_LATENCY; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // Clearing every tap on reset is what drops write-backs still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BF_LATENCY; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < BF_LATENCY; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  assign wb_en_o    = pipe_q[BF_LATENCY-1].en;
  assign wb_stage_o = pipe_q[BF_LATENCY-1].stage;
  assign wb_bfly_o  = pipe_q[BF_LATENCY-1].bfly;

endmodule

// File: rtl/fft_controller.sv
// rtl/fft_controller.sv - 16-point radix-2 FFT sequencer: load, 4 stages of 8 butterflies, unload.
// Optional FFT_BITREV_LOAD_EN stores incoming samples at bit-reversed addresses.
module fft_controller
  import fft_controller_pkg::*;
#(
  parameter int BF_LATENCY = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       load_we,
  output logic [3:0] load_addr,
  output logic [1:0] stage,
  output logic [2:0] butterfly,
  output logic       bf_issue,
  output logic       wb_en,
  output logic [1:0] wb_stage,
  output logic [2:0] wb_butterfly,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] rd_addr,
  output logic       out_last,
  output logic       busy,
  output logic       done
);

  fft_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] stage_q, stage_d;
  logic [2:0] bfly_q, bfly_d;
  logic [2:0] drain_q, drain_d;
  logic       done_q, done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      stage_q <= '0;
      bfly_q  <= '0;
      drain_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      bfly_q  <= bfly_d;
      drain_q <= drain_d;
      done_q  <= done_d;
    end
  end

  // Every counter is reloaded explicitly at its terminal value rather than left to roll over.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stage_d = stage_q;
    bfly_d  = bfly_q;
    drain_d = drain_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
        end
      end
      ST_LOAD: begin
        if (in_valid) begin
          if (cnt_q == 4'(FFT_N - 1)) begin
            state_d = ST_COMPUTE;
            cnt_d   = '0;
            stage_d = '0;
            bfly_d  = '0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      ST_COMPUTE: begin
        if (bfly_q == 3'(FFT_BFLIES - 1)) begin
          state_d = ST_DRAIN;
          drain_d = '0;
        end else begin
          bfly_d = bfly_q + 3'd1;
        end
      end
      ST_DRAIN: begin
        // Hold off the next stage until the last write-back of this one has landed in RAM.
        if (drain_q == 3'(BF_LATENCY - 1)) begin
          if (stage_q == 2'(FFT_STAGES - 1)) begin
            state_d = ST_UNLOAD;
            cnt_d   = '0;
          end else begin
            state_d = ST_COMPUTE;
            stage_d = stage_q + 2'd1;
            bfly_d  = '0;
          end
        end else begin
          drain_d = drain_q + 3'd1;
        end
      end
      ST_UNLOAD: begin
        if (out_ready) begin
          if (cnt_q == 4'(FFT_N - 1)) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_ready  = (state_q == ST_LOAD);
  assign load_we   = in_ready && in_valid;
`ifdef FFT_BITREV_LOAD_EN
  assign load_addr = in_ready ? bitrev4(cnt_q) : '0;
`else
  assign load_addr = in_ready ? cnt_q : '0;
`endif
  assign stage     = stage_q;
  assign butterfly = bfly_q;
  assign bf_issue  = (state_q == ST_COMPUTE);
  assign out_valid = (state_q == ST_UNLOAD);
  assign rd_addr   = out_valid ? cnt_q : '0;
  assign out_last  = out_valid && (cnt_q == 4'(FFT_N - 1));
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;

  fft_wb_delay #(
    .BF_LATENCY(BF_LATENCY)
  ) u_wb_delay (
    .clk       (clk),
    .rst       (rst),
    .issue_i   (bf_issue),
    .stage_i   (stage_q),
    .bfly_i    (bfly_q),
    .wb_en_o   (wb_en),
    .wb_stage_o(wb_stage),
    .wb_bfly_o (wb_butterfly)
  );

endmodule
